// File: rtl/fp_div_result_buffer.sv
// ----------------------------------------------------------------------------
// fp_div_result_buffer: credit-gated FIFO capturing FP divider results.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fp_div_result_buffer #(
  parameter int DEPTH      = 4,
  parameter int FP_WIDTH   = 32,
  parameter int TAG_WIDTH  = 6,
  parameter int STAT_WIDTH = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         issue_en_i,
  output logic                         issue_ready_o,
  input  logic                         div_valid_i,
  input  logic [FP_WIDTH-1:0]          div_res_i,
  input  logic [TAG_WIDTH-1:0]         div_tag_i,
  input  logic [STAT_WIDTH-1:0]        div_status_i,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic [FP_WIDTH-1:0]          res_o,
  output logic [TAG_WIDTH-1:0]         tag_o,
  output logic [STAT_WIDTH-1:0]        status_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         error_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_credits;
  logic                  r_error;
  logic [FP_WIDTH-1:0]   r_res_mem  [DEPTH];
  logic [TAG_WIDTH-1:0]  r_tag_mem  [DEPTH];
  logic [STAT_WIDTH-1:0] r_stat_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_issue_ok;
  logic w_issue_bad;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                       (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop       = !w_empty && res_ready_i;
  // A pop at full frees its slot in the same cycle, so the push is still taken.
  assign w_push      = div_valid_i && (!w_full || w_pop);
  assign w_drop      = div_valid_i && w_full && !w_pop;
  assign w_issue_ok  = issue_en_i && (r_credits != '0);
  assign w_issue_bad = issue_en_i && (r_credits == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_credits <= CW'(DEPTH);
      r_error   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_res_mem[i]  <= '0;
        r_tag_mem[i]  <= '0;
        r_stat_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_res_mem[r_wr_ptr[AW-1:0]]  <= div_res_i;
        r_tag_mem[r_wr_ptr[AW-1:0]]  <= div_tag_i;
        r_stat_mem[r_wr_ptr[AW-1:0]] <= div_status_i;
        r_wr_ptr                     <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_issue_ok, w_pop})
        2'b10:   r_credits <= r_credits - CW'(1);
        2'b01:   r_credits <= r_credits + CW'(1);
        default: r_credits <= r_credits;
      endcase
      if (w_drop || w_issue_bad) begin
        r_error <= 1'b1;
      end
    end
  end

  assign issue_ready_o = (r_credits != '0);
  assign res_valid_o   = !w_empty;
  assign res_o         = r_res_mem[r_rd_ptr[AW-1:0]];
  assign tag_o         = r_tag_mem[r_rd_ptr[AW-1:0]];
  assign status_o      = r_stat_mem[r_rd_ptr[AW-1:0]];
  assign count_o       = CW'(r_wr_ptr - r_rd_ptr);
  assign error_o       = r_error;

endmodule

`default_nettype wire
